ad_src_sel: RTL and testbench

Parametrised N-source selector for the AD sample path. It generalises the two-way test-pattern/real-data mux into NSRC sources. Switching is glitch-free: the output is muted, and the first HOLDOFF samples of a newly selected source are discarded. It also provides a registered output, an emitted-sample counter and a source-loss watchdog. It sits between the AD front-end and test-pattern generators and the downstream filter/packer.

---
 rtl/ad_src_sel.sv | 135 +++++++++++++
 tb/tb_ad_src_sel.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/ad_src_sel.sv
// N-source glitch-free sample selector: mute on switch, HOLDOFF-sample flush, loss watchdog.
// Latency 1 cycle src->ad; no backpressure (strobe-only path, samples are never stalled).
module ad_src_sel #(
    parameter int DW      = 24,
    parameter int NSRC    = 4,
    parameter int SELW    = 2,
    parameter int HOLDOFF = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic                 clk_sys,
    input  logic                 rst_n,
    input  logic [NSRC*DW-1:0]   src_data,
    input  logic [NSRC-1:0]      src_vld,
    input  logic [7:0]           cfg_sel,
    output logic [DW-1:0]        ad_data,
    output logic                 ad_vld,
    output logic [SELW-1:0]      sel_act,
    output logic                 sw_busy,
    output logic                 src_lost,
    output logic [15:0]          smp_cnt
);

    localparam int              LW     = $clog2(TIMEOUT + 1);
    localparam logic [LW-1:0]   TO_V   = LW'(TIMEOUT);
    localparam logic [7:0]      HOLD_V = 8'(HOLDOFF);

    typedef enum logic [1:0] {RUN, SKIP, MUTE} state_t;

    state_t          state;
    logic [7:0]      cfg_q;
    logic [7:0]      skip_cnt;
    logic [LW-1:0]   lost_cnt;

    logic            cur_vld;
    logic [DW-1:0]   cur_dat;
    logic            cfg_ok;
    logic            cfg_new;
    logic [7:0]      skip_nxt;

    always_comb begin
        cur_vld = 1'b0;
        cur_dat = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (sel_act == SELW'(i)) begin
                cur_vld = src_vld[i];
                cur_dat = src_data[i*DW +: DW];
            end
        end
    end

    // In-range requests always fit in SELW bits, so the low slice is a safe compare.
    assign cfg_ok   = (32'(cfg_q) < $unsigned(NSRC));
    assign cfg_new  = (cfg_q[SELW-1:0] != sel_act);
    assign skip_nxt = skip_cnt + 8'd1;

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            ad_data  <= '0;
            ad_vld   <= 1'b0;
            sel_act  <= '0;
            sw_busy  <= 1'b0;
            src_lost <= 1'b0;
            smp_cnt  <= '0;
            cfg_q    <= '0;
            state    <= RUN;
            skip_cnt <= '0;
            lost_cnt <= '0;
        end else begin
            cfg_q  <= cfg_sel;
            ad_vld <= 1'b0;
            case (state)
                RUN: begin
                    if (!cfg_ok) begin
                        state    <= MUTE;
                        sw_busy  <= 1'b1;
                        smp_cnt  <= '0;
                        lost_cnt <= '0;
                        src_lost <= 1'b0;
                    end else if (cfg_new) begin
                        // Switch wins over a same-cycle sample, which is dropped.
                        sel_act  <= cfg_q[SELW-1:0];
                        skip_cnt <= '0;
                        smp_cnt  <= '0;
                        state    <= SKIP;
                        sw_busy  <= 1'b1;
                        lost_cnt <= '0;
                        src_lost <= 1'b0;
                    end else if (cur_vld) begin
                        ad_vld   <= 1'b1;
                        ad_data  <= cur_dat;
                        smp_cnt  <= smp_cnt + 16'd1;
                        lost_cnt <= '0;
                        src_lost <= 1'b0;
                    end else begin
                        if (lost_cnt != TO_V)
                            lost_cnt <= lost_cnt + LW'(1);
                        src_lost <= (lost_cnt == TO_V);
                    end
                end
                SKIP: begin
                    if (!cfg_ok) begin
                        state <= MUTE;
                    end else if (cfg_new) begin
                        sel_act  <= cfg_q[SELW-1:0];
                        skip_cnt <= '0;
                    end else if (HOLDOFF == 0) begin
                        state   <= RUN;
                        sw_busy <= 1'b0;
                    end else if (cur_vld) begin
                        if (skip_nxt == HOLD_V) begin
                            state    <= RUN;
                            sw_busy  <= 1'b0;
                            skip_cnt <= '0;
                        end else begin
                            skip_cnt <= skip_nxt;
                        end
                    end
                end
                MUTE: begin
                    // Flush even when re-selecting the previous source.
                    if (cfg_ok) begin
                        sel_act  <= cfg_q[SELW-1:0];
                        skip_cnt <= '0;
                        state    <= SKIP;
                    end
                end
                default: begin
                    state   <= RUN;
                    sw_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ad_src_sel.sv
// Directed vector bench for ad_src_sel: table of per-cycle stimulus/expectations plus
// hand-written watchdog and asynchronous-reset sequences.
module tb_ad_src_sel;

    localparam int DW   = 24;
    localparam int NSRC = 4;
    localparam int SELW = 2;

    logic                clk_sys = 1'b0;
    logic                rst_n;
    logic [NSRC*DW-1:0]  src_data;
    logic [NSRC-1:0]     src_vld;
    logic [7:0]          cfg_sel;
    logic [DW-1:0]       ad_data;
    logic                ad_vld;
    logic [SELW-1:0]     sel_act;
    logic                sw_busy;
    logic                src_lost;
    logic [15:0]         smp_cnt;

    int total = 0;
    int bad   = 0;

    ad_src_sel #(.DW(DW), .NSRC(NSRC), .SELW(SELW), .HOLDOFF(4), .TIMEOUT(1024)) dut (
        .clk_sys  (clk_sys),
        .rst_n    (rst_n),
        .src_data (src_data),
        .src_vld  (src_vld),
        .cfg_sel  (cfg_sel),
        .ad_data  (ad_data),
        .ad_vld   (ad_vld),
        .sel_act  (sel_act),
        .sw_busy  (sw_busy),
        .src_lost (src_lost),
        .smp_cnt  (smp_cnt)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        logic [7:0]  sel;
        logic [3:0]  vld;
        logic [23:0] dat;
        logic        e_vld;
        logic [23:0] e_dat;
        logic [1:0]  e_sel;
        logic        e_busy;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [7:0] sel, input logic [3:0] vld, input logic [23:0] dat,
                       input logic e_vld, input logic [23:0] e_dat, input logic [1:0] e_sel,
                       input logic e_busy, input logic [15:0] e_cnt);
        vec_t v;
        v.sel = sel; v.vld = vld; v.dat = dat;
        v.e_vld = e_vld; v.e_dat = e_dat; v.e_sel = e_sel; v.e_busy = e_busy; v.e_cnt = e_cnt;
        tbl.push_back(v);
    endtask

    task automatic drive(input logic [7:0] sel, input logic [3:0] vld, input logic [23:0] dat);
        cfg_sel = sel;
        src_vld = vld;
        for (int i = 0; i < NSRC; i++)
            src_data[i*DW +: DW] = vld[i] ? dat : (24'hDEAD00 | 24'(i));
    endtask

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    function automatic logic [47:0] obs();
        return {3'b000, ad_vld, ad_data, sel_act, sw_busy, src_lost, smp_cnt};
    endfunction

    function automatic logic [47:0] pack(input logic e_vld, input logic [23:0] e_dat,
                                         input logic [1:0] e_sel, input logic e_busy,
                                         input logic e_lost, input logic [15:0] e_cnt);
        return {3'b000, e_vld, e_dat, e_sel, e_busy, e_lost, e_cnt};
    endfunction

    task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got vld=%b dat=%h sel=%0d busy=%b lost=%b cnt=%0d, want vld=%b dat=%h sel=%0d busy=%b lost=%b cnt=%0d",
                     nm, act[44], act[43:20], act[19:18], act[17], act[16], act[15:0],
                     exp[44], exp[43:20], exp[19:18], exp[17], exp[16], exp[15:0]);
        end
    endtask

    initial begin
        // sel, vld, dat | exp vld, dat, sel, busy, cnt
        // Forwarding from src0, src1 strobe ignored
        add(8'h00, 4'h1, 24'h000001, 1, 24'h000001, 0, 0, 1);
        add(8'h00, 4'h0, 24'h000000, 0, 24'h000001, 0, 0, 1);
        add(8'h00, 4'h0, 24'h000000, 0, 24'h000001, 0, 0, 1);
        add(8'h00, 4'h0, 24'h000000, 0, 24'h000001, 0, 0, 1);
        add(8'h00, 4'h1, 24'h000002, 1, 24'h000002, 0, 0, 2);
        add(8'h00, 4'h0, 24'h000000, 0, 24'h000002, 0, 0, 2);
        add(8'h00, 4'h0, 24'h000000, 0, 24'h000002, 0, 0, 2);
        add(8'h00, 4'h2, 24'h000055, 0, 24'h000002, 0, 0, 2);
        add(8'h00, 4'h1, 24'h000003, 1, 24'h000003, 0, 0, 3);
        // Switch to src2: src0 sample in switch cycle dropped, four src2 samples flushed
        add(8'h02, 4'h0, 24'h000000, 0, 24'h000003, 0, 0, 3);
        add(8'h02, 4'h1, 24'h000077, 0, 24'h000003, 2, 1, 0);
        add(8'h02, 4'h4, 24'hA00000, 0, 24'h000003, 2, 1, 0);
        add(8'h02, 4'h0, 24'h000000, 0, 24'h000003, 2, 1, 0);
        add(8'h02, 4'h4, 24'hA00001, 0, 24'h000003, 2, 1, 0);
        add(8'h02, 4'h4, 24'hA00002, 0, 24'h000003, 2, 1, 0);
        add(8'h02, 4'h4, 24'hA00003, 0, 24'h000003, 2, 0, 0);
        add(8'h02, 4'h4, 24'hA00004, 1, 24'hA00004, 2, 0, 1);
        add(8'h02, 4'h4, 24'hA00005, 1, 24'hA00005, 2, 0, 2);
        // Mute, then select src1 with full flush
        add(8'hFF, 4'h0, 24'h000000, 0, 24'hA00005, 2, 0, 2);
        add(8'hFF, 4'h4, 24'h123456, 0, 24'hA00005, 2, 1, 0);
        add(8'hFF, 4'h4, 24'h111111, 0, 24'hA00005, 2, 1, 0);
        add(8'h01, 4'h0, 24'h000000, 0, 24'hA00005, 2, 1, 0);
        add(8'h01, 4'h2, 24'hB00000, 0, 24'hA00005, 1, 1, 0);
        add(8'h01, 4'h2, 24'hB00001, 0, 24'hA00005, 1, 1, 0);
        add(8'h01, 4'h2, 24'hB00002, 0, 24'hA00005, 1, 1, 0);
        add(8'h01, 4'h2, 24'hB00003, 0, 24'hA00005, 1, 1, 0);
        add(8'h01, 4'h2, 24'hB00004, 0, 24'hA00005, 1, 0, 0);
        add(8'h01, 4'h2, 24'hB00005, 1, 24'hB00005, 1, 0, 1);
        // Mute and re-select src1 (flush still done), retarget to src3 mid-flush
        add(8'hFF, 4'h0, 24'h000000, 0, 24'hB00005, 1, 0, 1);
        add(8'h01, 4'h0, 24'h000000, 0, 24'hB00005, 1, 1, 0);
        add(8'h01, 4'h0, 24'h000000, 0, 24'hB00005, 1, 1, 0);
        add(8'h01, 4'h2, 24'hC00001, 0, 24'hB00005, 1, 1, 0);
        add(8'h03, 4'h2, 24'hC00002, 0, 24'hB00005, 1, 1, 0);
        add(8'h03, 4'h2, 24'hC00003, 0, 24'hB00005, 3, 1, 0);
        add(8'h03, 4'h8, 24'hD00001, 0, 24'hB00005, 3, 1, 0);
        add(8'h03, 4'h2, 24'hC00009, 0, 24'hB00005, 3, 1, 0);
        add(8'h03, 4'h8, 24'hD00002, 0, 24'hB00005, 3, 1, 0);
        add(8'h03, 4'h8, 24'hD00003, 0, 24'hB00005, 3, 1, 0);
        add(8'h03, 4'h8, 24'hD00004, 0, 24'hB00005, 3, 0, 0);
        add(8'h03, 4'h8, 24'hD00005, 1, 24'hD00005, 3, 0, 1);

        rst_n = 1'b0;
        drive(8'h00, 4'h0, 24'h0);
        #12;
        chk("reset", obs(), pack(0, 24'h0, 0, 0, 0, 16'h0));
        @(posedge clk_sys);
        #1;
        rst_n = 1'b1;

        for (int k = 0; k < tbl.size(); k++) begin
            drive(tbl[k].sel, tbl[k].vld, tbl[k].dat);
            step();
            chk($sformatf("vec%0d", k), obs(),
                pack(tbl[k].e_vld, tbl[k].e_dat, tbl[k].e_sel, tbl[k].e_busy, 1'b0, tbl[k].e_cnt));
        end

        // Watchdog: src3 silent after its last sample
        drive(8'h03, 4'h0, 24'h0);
        for (int k = 0; k < 1024; k++) step();
        chk("lost_early", obs(), pack(0, 24'hD00005, 3, 0, 0, 16'd1));
        step();
        chk("lost_set", obs(), pack(0, 24'hD00005, 3, 0, 1, 16'd1));
        for (int k = 0; k < 3; k++) step();
        chk("lost_hold", obs(), pack(0, 24'hD00005, 3, 0, 1, 16'd1));
        drive(8'h03, 4'h8, 24'hE00001);
        step();
        chk("lost_clear", obs(), pack(1, 24'hE00001, 3, 0, 0, 16'd2));

        // Asynchronous reset in the middle of a flush
        drive(8'h01, 4'h0, 24'h0);
        step();
        step();
        chk("pre_reset", obs(), pack(0, 24'hE00001, 1, 1, 0, 16'd0));
        drive(8'h01, 4'h2, 24'hF00000);
        step();
        rst_n = 1'b0;
        drive(8'h00, 4'h0, 24'h0);
        #1;
        chk("rst_async", obs(), pack(0, 24'h0, 0, 0, 0, 16'h0));
        step();
        chk("rst_hold", obs(), pack(0, 24'h0, 0, 0, 0, 16'h0));
        rst_n = 1'b1;
        drive(8'h00, 4'h1, 24'hF00001);
        step();
        chk("post_rst", obs(), pack(1, 24'hF00001, 0, 0, 0, 16'd1));
        drive(8'h00, 4'h0, 24'h0);
        step();
        chk("post_rst_idle", obs(), pack(0, 24'hF00001, 0, 0, 0, 16'd1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
